// File: rtl/iob_mem_responder_pkg.sv
// Shared definitions for the IOb memory responder: FSM encoding and the
// REQ/RESP bus field layout, so no module re-derives bit offsets.
package iob_mem_responder_pkg;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_t;

  // RESP = {rdata, rvalid, ready}
  localparam int RESP_READY_BIT  = 0;
  localparam int RESP_RVALID_BIT = 1;
  localparam int RESP_RDATA_LSB  = 2;

  // REQ = {valid, addr, wdata, wstrb}
  localparam int REQ_WSTRB_LSB = 0;

  function automatic int req_w(input int addr_w, input int data_w);
    return 1 + addr_w + data_w + data_w / 8;
  endfunction

  function automatic int resp_w(input int data_w);
    return data_w + 2;
  endfunction

  function automatic int req_wdata_lsb(input int data_w);
    return data_w / 8;
  endfunction

  function automatic int req_addr_lsb(input int data_w);
    return data_w / 8 + data_w;
  endfunction

  function automatic int req_valid_bit(input int addr_w, input int data_w);
    return data_w / 8 + data_w + addr_w;
  endfunction

endpackage

// File: rtl/iob_ram_sp_be.sv
// Single-port word RAM with per-byte write enables and a registered read port.
// The read register only loads on reads, so it holds its last value otherwise.
module iob_ram_sp_be #(
  parameter int DATA_W = 32,
  parameter int ADDR_W = 12
) (
  input  logic                clk_i,
  input  logic                arst_n_i,
  input  logic                en_i,
  input  logic [DATA_W/8-1:0] we_i,
  input  logic [ADDR_W-1:0]   addr_i,
  input  logic [DATA_W-1:0]   wdata_i,
  output logic [DATA_W-1:0]   rdata_o
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];
  logic [DATA_W-1:0] r_rdata;

  // Memory contents are intentionally not reset.
  always_ff @(posedge clk_i) begin
    if (en_i) begin
      for (int b = 0; b < DATA_W / 8; b++) begin
        if (we_i[b]) r_mem[addr_i][b*8 +: 8] <= wdata_i[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) r_rdata <= '0;
    else if (en_i && (we_i == '0)) r_rdata <= r_mem[addr_i];
  end

  assign rdata_o = r_rdata;

endmodule

// File: rtl/iob_mem_responder.sv
// IOb native-bus subordinate backed by a byte-writable word RAM, with
// programmable wait states after each accept and a fixed read latency.
module iob_mem_responder
  import iob_mem_responder_pkg::*;
#(
  parameter int ADDR_W      = 32,
  parameter int DATA_W      = 32,
  parameter int MEM_ADDR_W  = 12,
  parameter int WAIT_STATES = 0,
  parameter int READ_LAT    = 1
) (
  input  logic                            clk_i,
  input  logic                            arst_n_i,
  input  logic                            cke_i,
  input  logic [req_w(ADDR_W, DATA_W)-1:0] req_i,
  output logic [resp_w(DATA_W)-1:0]        resp_o,
  output state_t                          dbg_state_o
);

  localparam int STRB_W    = DATA_W / 8;
  localparam int REQ_VALID = req_valid_bit(ADDR_W, DATA_W);
  localparam int REQ_ADDR  = req_addr_lsb(DATA_W);
  localparam int REQ_WDATA = req_wdata_lsb(DATA_W);
  localparam logic [3:0] WAIT_LOAD = 4'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  if (WAIT_STATES < 0 || WAIT_STATES > 15) begin : g_bad_wait_states
    $error("iob_mem_responder: WAIT_STATES must be 0..15");
  end
  if (READ_LAT < 1 || READ_LAT > 4) begin : g_bad_read_lat
    $error("iob_mem_responder: READ_LAT must be 1..4");
  end
  if (ADDR_W < MEM_ADDR_W + 2 || (DATA_W % 8) != 0) begin : g_bad_widths
    $error("iob_mem_responder: inconsistent ADDR_W/MEM_ADDR_W/DATA_W");
  end

  // Valid/ready: a request transfers on a rising edge where valid, ready and
  // cke_i are all high; the initiator holds the request stable until then.
  logic              w_valid;
  logic [ADDR_W-1:0] w_addr;
  logic [DATA_W-1:0] w_wdata;
  logic [STRB_W-1:0] w_wstrb;
  logic              w_accept;
  logic              w_rd;
  logic              w_unused_addr;
  logic [DATA_W-1:0] w_ram_rdata;
  logic              w_rvalid;
  logic [DATA_W-1:0] w_rdata;

  state_t            r_state;
  logic [3:0]        r_cnt;
  logic              r_ready;
  logic [READ_LAT-1:0] r_pv;

  assign w_valid  = req_i[REQ_VALID];
  assign w_addr   = req_i[REQ_ADDR +: ADDR_W];
  assign w_wdata  = req_i[REQ_WDATA +: DATA_W];
  assign w_wstrb  = req_i[REQ_WSTRB_LSB +: STRB_W];
  assign w_accept = w_valid & r_ready & cke_i;
  assign w_rd     = w_accept & ~(|w_wstrb);
  // Byte offset and upper address bits alias onto the same word.
  assign w_unused_addr = ^w_addr;

  iob_ram_sp_be #(
    .DATA_W (DATA_W),
    .ADDR_W (MEM_ADDR_W)
  ) u_ram (
    .clk_i    (clk_i),
    .arst_n_i (arst_n_i),
    .en_i     (w_accept),
    .we_i     (w_wstrb),
    .addr_i   (w_addr[MEM_ADDR_W+1:2]),
    .wdata_i  (w_wdata),
    .rdata_o  (w_ram_rdata)
  );

  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_state <= ST_IDLE;
      r_cnt   <= '0;
      r_ready <= 1'b1;
    end else if (cke_i) begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept && (WAIT_STATES > 0)) begin
            r_state <= ST_WAIT;
            r_ready <= 1'b0;
            r_cnt   <= WAIT_LOAD;
          end
        end
        ST_WAIT: begin
          if (r_cnt == 4'd0) begin
            r_state <= ST_IDLE;
            r_ready <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 4'd1;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  // r_pv[0] marks the RAM read register; later bits are the extra delay stages.
  always_ff @(posedge clk_i or negedge arst_n_i) begin
    if (!arst_n_i) begin
      r_pv <= '0;
    end else if (cke_i) begin
      r_pv[0] <= w_rd;
      for (int i = 1; i < READ_LAT; i++) r_pv[i] <= r_pv[i-1];
    end
  end

  if (READ_LAT == 1) begin : g_lat1
    assign w_rdata = w_ram_rdata;
  end else begin : g_latn
    logic [DATA_W-1:0] r_pd [READ_LAT-1];

    // Each stage loads only behind a valid read, so the output holds between pulses.
    always_ff @(posedge clk_i or negedge arst_n_i) begin
      if (!arst_n_i) begin
        for (int i = 0; i < READ_LAT - 1; i++) r_pd[i] <= '0;
      end else if (cke_i) begin
        if (r_pv[0]) r_pd[0] <= w_ram_rdata;
        for (int i = 1; i < READ_LAT - 1; i++) begin
          if (r_pv[i]) r_pd[i] <= r_pd[i-1];
        end
      end
    end

    assign w_rdata = r_pd[READ_LAT-2];
  end

  assign w_rvalid = r_pv[READ_LAT-1];

  assign resp_o[RESP_READY_BIT]            = r_ready;
  assign resp_o[RESP_RVALID_BIT]           = w_rvalid;
  assign resp_o[RESP_RDATA_LSB +: DATA_W]  = w_rdata;
  assign dbg_state_o                       = r_state;

endmodule

// File: tb/tb_iob_mem_responder.sv
// Bench for iob_mem_responder: three instances (WS0/LAT1, WS3/LAT1, WS0/LAT3)
// share one clock; a per-instance scoreboard checks read data and arrival cycle.
module tb_iob_mem_responder;
  import iob_mem_responder_pkg::*;

  localparam int AW     = 32;
  localparam int DW     = 32;
  localparam int MAW    = 12;
  localparam int REQ_W  = 1 + AW + DW + DW / 8;
  localparam int RESP_W = DW + 2;

  logic clk;
  logic rst_n;
  logic cke;
  logic [REQ_W-1:0]  req0, req1, req2;
  logic [RESP_W-1:0] resp0, resp1, resp2;
  state_t            dbg0, dbg1, dbg2;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;

  logic [DW-1:0] exp_q   [3][$];
  int            exp_t_q [3][$];

  typedef struct {
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic [31:0] exp;
  } vec_t;

  vec_t tv [16];

  iob_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .MEM_ADDR_W(MAW), .WAIT_STATES(0), .READ_LAT(1)) u_dut0 (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke), .req_i(req0), .resp_o(resp0), .dbg_state_o(dbg0));
  iob_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .MEM_ADDR_W(MAW), .WAIT_STATES(3), .READ_LAT(1)) u_dut1 (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke), .req_i(req1), .resp_o(resp1), .dbg_state_o(dbg1));
  iob_mem_responder #(.ADDR_W(AW), .DATA_W(DW), .MEM_ADDR_W(MAW), .WAIT_STATES(0), .READ_LAT(3)) u_dut2 (
    .clk_i(clk), .arst_n_i(rst_n), .cke_i(cke), .req_i(req2), .resp_o(resp2), .dbg_state_o(dbg2));

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (cycle %0d)", name, got, exp, cyc);
    end
  endtask

  function automatic logic [RESP_W-1:0] resp_of(input int k);
    case (k)
      0:       return resp0;
      1:       return resp1;
      default: return resp2;
    endcase
  endfunction

  function automatic int lat_of(input int k);
    return (k == 2) ? 3 : 1;
  endfunction

  task automatic set_req(input int k, input logic v, input logic [31:0] addr,
                         input logic [31:0] wdata, input logic [3:0] wstrb);
    case (k)
      0:       req0 = {v, addr, wdata, wstrb};
      1:       req1 = {v, addr, wdata, wstrb};
      default: req2 = {v, addr, wdata, wstrb};
    endcase
  endtask

  // ---------------- driver ----------------
  // Holds the request until accepted; reads push {data, arrival cycle}.
  task automatic issue(input int k, input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [3:0] wstrb, input logic [31:0] exp, input int extra,
                       output int acc_cyc, output int waits);
    logic acc;
    logic [31:0] wd;
    int n;
    acc = 1'b0;
    n   = 0;
    wd  = (wstrb == 4'h0) ? 32'($urandom()) : wdata;
    set_req(k, 1'b1, addr, wd, wstrb);
    while (!acc && n < 64) begin
      @(negedge clk);
      acc = resp_of(k)[0] & cke;
      @(posedge clk);
      if (!acc) n++;
    end
    #1;
    set_req(k, 1'b0, addr, wd, wstrb);
    acc_cyc = cyc;
    waits   = n;
    if (!acc) begin
      n_checks++;
      n_fail++;
      $display("FAIL issue_timeout dut%0d: got no accept, required accept within 64 cycles", k);
    end else if (wstrb == 4'h0) begin
      exp_q[k].push_back(exp);
      exp_t_q[k].push_back(cyc + lat_of(k) - 1 + extra);
    end
  endtask

  // ---------------- scoreboard ----------------
  task automatic mon(input int k, input logic [RESP_W-1:0] r);
    logic [31:0] e;
    int t;
    if (r[1]) begin
      if (exp_q[k].size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL dut%0d_unexpected_rvalid: got rvalid=1 rdata=0x%08h, required rvalid=0 (cycle %0d)",
                 k, r[RESP_W-1:2], cyc);
      end else begin
        e = exp_q[k].pop_front();
        t = exp_t_q[k].pop_front();
        check($sformatf("dut%0d_rdata", k), r[RESP_W-1:2], e);
        check($sformatf("dut%0d_rvalid_cycle", k), 32'(cyc), 32'(t));
      end
    end
  endtask

  always @(negedge clk) begin
    mon(0, resp0);
    mon(1, resp1);
    mon(2, resp2);
  end

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // ---------------- test ----------------
  initial begin
    int a, w, a_prev, cnt;

    tv[0]  = '{addr: 32'h0000_0010, wdata: 32'hDEAD_BEEF, wstrb: 4'hF, exp: 32'h0};
    tv[1]  = '{addr: 32'h0000_0010, wdata: 32'h0,         wstrb: 4'h0, exp: 32'hDEAD_BEEF};
    tv[2]  = '{addr: 32'h0000_0010, wdata: 32'h0000_AA00, wstrb: 4'h2, exp: 32'h0};
    // Only byte 1 (0xBE) is replaced.
    tv[3]  = '{addr: 32'h0000_0010, wdata: 32'h0,         wstrb: 4'h0, exp: 32'hDEAD_AAEF};
    tv[4]  = '{addr: 32'h0000_0012, wdata: 32'h0,         wstrb: 4'h0, exp: 32'hDEAD_AAEF};
    tv[5]  = '{addr: 32'h0000_4010, wdata: 32'h0,         wstrb: 4'h0, exp: 32'hDEAD_AAEF};
    tv[6]  = '{addr: 32'h0000_0020, wdata: 32'h1234_5678, wstrb: 4'hF, exp: 32'h0};
    tv[7]  = '{addr: 32'h0000_0020, wdata: 32'h0000_00CC, wstrb: 4'h1, exp: 32'h0};
    tv[8]  = '{addr: 32'h0000_0020, wdata: 32'h9900_0000, wstrb: 4'h8, exp: 32'h0};
    tv[9]  = '{addr: 32'h0000_0020, wdata: 32'h0,         wstrb: 4'h0, exp: 32'h9934_56CC};
    tv[10] = '{addr: 32'h0000_0024, wdata: 32'hCAFE_F00D, wstrb: 4'hF, exp: 32'h0};
    tv[11] = '{addr: 32'h0000_0024, wdata: 32'h0,         wstrb: 4'h0, exp: 32'hCAFE_F00D};
    tv[12] = '{addr: 32'h0000_0024, wdata: 32'hFFFF_FFFF, wstrb: 4'hC, exp: 32'h0};
    tv[13] = '{addr: 32'h0000_0024, wdata: 32'h0,         wstrb: 4'h0, exp: 32'hFFFF_F00D};
    tv[14] = '{addr: 32'h0000_3FFC, wdata: 32'h5A5A_5A5A, wstrb: 4'hF, exp: 32'h0};
    tv[15] = '{addr: 32'hFFFF_7FFF, wdata: 32'h0,         wstrb: 4'h0, exp: 32'h5A5A_5A5A};

    rst_n = 1'b0;
    cke   = 1'b1;
    req0  = '0;
    req1  = '0;
    req2  = '0;

    // Reset values, during and right after reset.
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_hold_ready_dut1", 32'(resp1[0]), 32'd1);
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_ready_dut%0d", k),  32'(resp_of(k)[0]), 32'd1);
      check($sformatf("rst_rvalid_dut%0d", k), 32'(resp_of(k)[1]), 32'd0);
      check($sformatf("rst_rdata_dut%0d", k),  resp_of(k)[RESP_W-1:2], 32'd0);
    end
    check("rst_state_dut1", 32'(dbg1), 32'(ST_IDLE));
    @(posedge clk);
    #1;

    // Table vectors, back-to-back on the zero-wait, latency-1 instance.
    for (int i = 0; i < 16; i++) begin
      issue(0, tv[i].addr, tv[i].wdata, tv[i].wstrb, tv[i].exp, 0, a, w);
      check($sformatf("vec%0d_ready_wait", i), 32'(w), 32'd0);
    end
    idle_cycles(4);
    check("dut0_queue_drained", 32'(exp_q[0].size()), 32'd0);

    // Wait states = 3: ready low for 3 cycles after each accept.
    issue(1, 32'h0, 32'h1111_1111, 4'hF, 32'h0, 0, a, w);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      check($sformatf("ws_ready_low%0d", i), 32'(resp1[0]), 32'd0);
      check($sformatf("ws_state_wait%0d", i), 32'(dbg1), 32'(ST_WAIT));
    end
    @(negedge clk);
    check("ws_ready_back", 32'(resp1[0]), 32'd1);
    check("ws_state_idle", 32'(dbg1), 32'(ST_IDLE));
    issue(1, 32'h4, 32'h2222_2222, 4'hF, 32'h0, 0, a, w);
    issue(1, 32'h8, 32'h3333_3333, 4'hF, 32'h0, 0, a, w);
    check("ws_write_waits", 32'(w), 32'd3);
    issue(1, 32'h0, 32'h0, 4'h0, 32'h1111_1111, 0, a_prev, w);
    issue(1, 32'h4, 32'h0, 4'h0, 32'h2222_2222, 0, a, w);
    check("ws_accept_spacing1", 32'(a - a_prev), 32'd4);
    a_prev = a;
    issue(1, 32'h8, 32'h0, 4'h0, 32'h3333_3333, 0, a, w);
    check("ws_accept_spacing2", 32'(a - a_prev), 32'd4);
    idle_cycles(6);
    check("dut1_queue_drained", 32'(exp_q[1].size()), 32'd0);

    // Read latency 3: four pipelined reads, four consecutive pulses.
    for (int i = 0; i < 4; i++) begin
      issue(2, 32'(4 * i), 32'h1010_1010 * (i + 1), 4'hF, 32'h0, 0, a, w);
    end
    for (int i = 0; i < 4; i++) begin
      issue(2, 32'(4 * i), 32'h0, 4'h0, 32'h1010_1010 * (i + 1), 0, a, w);
      check($sformatf("lat3_read%0d_wait", i), 32'(w), 32'd0);
    end
    idle_cycles(6);
    check("dut2_queue_drained", 32'(exp_q[2].size()), 32'd0);

    // Clock enable low for 5 cycles while a read is in flight.
    issue(2, 32'h8, 32'h0, 4'h0, 32'h3030_3030, 5, a, w);
    cke = 1'b0;
    repeat (5) @(posedge clk);
    #1 cke = 1'b1;
    idle_cycles(6);
    check("cke_queue_drained", 32'(exp_q[2].size()), 32'd0);

    // Reset with two reads in flight: both are discarded.
    issue(2, 32'h0, 32'h0, 4'h0, 32'h1010_1010, 0, a, w);
    issue(2, 32'h4, 32'h0, 4'h0, 32'h2020_2020, 0, a, w);
    rst_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      exp_q[k].delete();
      exp_t_q[k].delete();
    end
    @(posedge clk);
    #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid_ready", 32'(resp2[0]), 32'd1);
    check("rst_mid_rdata", resp2[RESP_W-1:2], 32'd0);
    cnt = 0;
    for (int i = 0; i < 8; i++) begin
      if (resp2[1]) cnt++;
      @(negedge clk);
    end
    check("rst_mid_no_rvalid", 32'(cnt), 32'd0);
    @(posedge clk);
    #1;
    // Memory contents survive reset.
    issue(2, 32'hC, 32'h0, 4'h0, 32'h4040_4040, 0, a, w);
    idle_cycles(6);
    for (int k = 0; k < 3; k++) begin
      check($sformatf("final_queue_empty_dut%0d", k), 32'(exp_q[k].size()), 32'd0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: got simulation still running, required completion before 200000 time units");
    $fatal(1, "watchdog expired");
  end

endmodule
